// File: rtl/vram_sched_pkg.sv
// Shared types and constants for the VRAM write scheduler: FSM state encoding,
// the blank-character code and the default screen geometry.
package vram_sched_pkg;

  localparam int SCREEN_COLS  = 80;
  localparam int SCREEN_ROWS  = 30;
  localparam int SCREEN_CELLS = SCREEN_COLS * SCREEN_ROWS;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the read word is presented
// combinationally from the head entry so a pop consumes it in the same cycle.
module sync_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: the storage array has no reset; only the pointers and count define
  // which entries are valid, so clearing the data would just cost flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates the single-port char memory: scanout reads in active video, queued host
// writes drain during blanking. Optional screen clear is built with VRAM_SCHED_CLEAR_EN.
module vram_write_scheduler import vram_sched_pkg::*; #(
  parameter int COLS       = SCREEN_COLS,
  parameter int ROWS       = SCREEN_ROWS,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blank,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              clr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              addr_err
);

  localparam int CELLS = COLS * ROWS;
  localparam int FW    = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              addr_err_q, addr_err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              accept, in_range, push, pop;
  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_rdata;
  logic [CNT_W-1:0]  fifo_count, count_next;

`ifdef VRAM_SCHED_CLEAR_EN
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
`else
  logic unused_clr_req;
  assign unused_clr_req = clr_req;
`endif

  assign accept   = host_valid && ready_q;
  assign in_range = (host_addr < ADDR_W'(CELLS));
  assign push     = accept && in_range;

  sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({host_addr, host_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = scan_addr;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    pop         = 1'b0;
`ifdef VRAM_SCHED_CLEAR_EN
    clr_ptr_d   = clr_ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef VRAM_SCHED_CLEAR_EN
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end else
`endif
        if (blank && !fifo_empty) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (blank && !fifo_empty) begin
          pop         = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = fifo_rdata[FW-1:DATA_W];
          mem_wdata_d = fifo_rdata[DATA_W-1:0];
          // Leave once this pop empties the queue and nothing new arrived.
          if (fifo_count == CNT_W'(1) && !push) state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef VRAM_SCHED_CLEAR_EN
      ST_CLEAR: begin
        if (clr_req) begin
          clr_ptr_d = '0;
        end else if (blank) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = clr_ptr_q;
          mem_wdata_d = DATA_W'(CHAR_SPACE);
          if (clr_ptr_q == ADDR_W'(CELLS - 1)) state_d = ST_IDLE;
          else clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign ready_d    = (count_next != CNT_W'(FIFO_DEPTH));
  assign busy_d     = (count_next != '0) || (state_d == ST_CLEAR);
  assign addr_err_d = addr_err_q || (accept && !in_range);

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef VRAM_SCHED_CLEAR_EN
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
`else
      state_q   <= ST_IDLE;
`endif
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      addr_err_q  <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
`ifdef VRAM_SCHED_CLEAR_EN
      clr_ptr_q   <= clr_ptr_d;
`endif
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      addr_err_q  <= addr_err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign host_ready = ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Self-checking bench for vram_write_scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_vram_write_scheduler;

  localparam int CELLS = 2400;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk, rst, blank, host_valid, host_ready, clr_req;
  logic        mem_we, busy, addr_err;
  logic [11:0] scan_addr, host_addr, mem_addr;
  logic [7:0]  host_data, mem_wdata;

  vram_write_scheduler dut (
    .clk(clk), .rst(rst), .blank(blank), .scan_addr(scan_addr),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_data(host_data), .clr_req(clr_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .busy(busy), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending writes, "draining" flag, clear progress.
  wr_t         q[$];
  wr_t         wlog[$];
  bit          draining, clearing, m_err, m_ready, m_we, m_busy;
  int          clr_ptr;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit  push_ok, was_nonempty, was_draining, was_clearing, popped;
    wr_t e;
    if (rst) begin
      q.delete();
      draining = 0; m_err = 0; m_ready = 0; m_we = 0; m_busy = 0;
      m_addr = '0; m_wdata = '0; clr_ptr = 0;
`ifdef VRAM_SCHED_CLEAR_EN
      clearing = 1;
`else
      clearing = 0;
`endif
      return;
    end
    push_ok      = host_valid && m_ready;
    was_nonempty = (q.size() != 0);
    was_draining = draining;
    was_clearing = clearing;
    popped       = 0;
    m_we         = 0;
    m_addr       = scan_addr;
    if (clearing) begin
      if (clr_req) clr_ptr = 0;
      else if (blank) begin
        m_we = 1; m_addr = 12'(clr_ptr); m_wdata = 8'h20;
        if (clr_ptr == CELLS - 1) clearing = 0;
        else clr_ptr++;
      end
    end else if (draining && blank && q.size() != 0) begin
      e = q.pop_front();
      m_we = 1; m_addr = e.a; m_wdata = e.d; popped = 1;
    end
    if (push_ok) begin
      if (int'(host_addr) >= CELLS) m_err = 1;
      else q.push_back('{a: host_addr, d: host_data});
    end
    if (was_clearing) draining = 0;
    else if (was_draining) draining = popped && (q.size() != 0);
    else begin
`ifdef VRAM_SCHED_CLEAR_EN
      if (clr_req) begin
        clearing = 1; clr_ptr = 0;
      end
`endif
      draining = !clearing && blank && was_nonempty;
    end
    m_ready = (q.size() != 8);
    m_busy  = (q.size() != 0) || clearing;
  endtask

  task automatic step();
    scan_addr = 12'($urandom_range(0, CELLS - 1));
    @(posedge clk);
    model_update();
    #1;
    check("mem_we", mem_we, m_we);
    check("mem_addr", mem_addr, m_addr);
    if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    check("busy", busy, m_busy);
    check("addr_err", addr_err, m_err);
    check("host_ready", host_ready, m_ready);
    if (mem_we === 1'b1) wlog.push_back('{a: mem_addr, d: mem_wdata});
  endtask

  task automatic push(input logic [11:0] a, input logic [7:0] d);
    host_valid = 1'b1; host_addr = a; host_data = d;
    step();
    host_valid = 1'b0;
  endtask

  task automatic wait_clear_done();
    int n = 0;
    while (busy === 1'b1 && n < 20000) begin
      blank = ($urandom_range(0, 1) == 1);
      step();
      n++;
    end
    check("clear_done", busy, 1'b0);
    blank = 1'b0;
  endtask

  initial begin
    wr_t exp_q[$];
    int  n;
    rst = 1'b1; blank = 1'b0; host_valid = 1'b0; clr_req = 1'b0;
    host_addr = '0; host_data = '0; scan_addr = '0;
    step(); step();
    check("rst_we", mem_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", host_ready, 1'b0);
    check("rst_addr", mem_addr, 12'd0);
    wlog.delete();
    rst = 1'b0;
    step();

`ifdef VRAM_SCHED_CLEAR_EN
    // Auto clear after reset, random blanking, then a requested clear restarted midway.
    wait_clear_done();
    begin
      bit seen[CELLS];
      int uniq = 0;
      foreach (wlog[i]) if (wlog[i].d == 8'h20 && !seen[wlog[i].a]) begin
        seen[wlog[i].a] = 1; uniq++;
      end
      check("clear_cells", uniq, CELLS);
      check("clear_writes", wlog.size(), CELLS);
    end
    clr_req = 1'b1; step(); clr_req = 1'b0;
    blank = 1'b1;
    repeat (50) step();
    clr_req = 1'b1; step(); clr_req = 1'b0;
    wait_clear_done();
`endif

    // Three writes while active video, then one blank window.
    blank = 1'b0;
    push(12'd0, 8'h41); push(12'd1, 8'h42); push(12'd2, 8'h43);
    check("t1_busy", busy, 1'b1);
    wlog.delete();
    blank = 1'b1;
    repeat (5) step();
    blank = 1'b0;
    check("t1_count", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      check("t1_addr", wlog[i].a, 12'(i));
      check("t1_data", wlog[i].d, 8'h41 + 8'(i));
    end
    check("t1_busy_after", busy, 1'b0);

    // Fill the queue, then release it.
    for (int i = 0; i < 8; i++) push(12'(100 + i), 8'($urandom));
    check("t2_full", host_ready, 1'b0);
    blank = 1'b1;
    step();
    check("t2_still_full", host_ready, 1'b0);
    step();
    check("t2_ready_back", host_ready, 1'b1);
    repeat (9) step();
    blank = 1'b0;
    step();

    // Short blank window: two writes, the rest in the next window.
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{a: 12'($urandom_range(0, CELLS - 1)), d: 8'($urandom)});
      push(exp_q[i].a, exp_q[i].d);
    end
    wlog.delete();
    blank = 1'b1;
    repeat (3) step();
    blank = 1'b0;
    repeat (2) step();
    check("t3_partial", wlog.size(), 2);
    blank = 1'b1;
    repeat (6) step();
    blank = 1'b0;
    check("t3_total", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      check("t3_addr", wlog[i].a, exp_q[i].a);
      check("t3_data", wlog[i].d, exp_q[i].d);
    end

    // Out-of-range address is dropped and flagged stickily.
    wlog.delete();
    push(12'd2400, 8'h5a);
    check("t4_err", addr_err, 1'b1);
    check("t4_busy", busy, 1'b0);
    push(12'd2399, 8'h5b);
    blank = 1'b1;
    repeat (4) step();
    blank = 1'b0;
    check("t4_one_write", wlog.size(), 1);
    check("t4_err_sticky", addr_err, 1'b1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) push(12'(200 + i), 8'h61 + 8'(i));
    blank = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    check("t5_we", mem_we, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_err", addr_err, 1'b0);
    rst = 1'b0;
    wlog.delete();
    repeat (10) step();
    n = 0;
    foreach (wlog[i]) if (wlog[i].d != 8'h20) n++;
    check("t5_no_stale", n, 0);
    blank = 1'b0;
`ifdef VRAM_SCHED_CLEAR_EN
    wait_clear_done();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      blank      = ($urandom_range(0, 2) != 0);
      host_valid = ($urandom_range(0, 1) == 1);
      host_addr  = ($urandom_range(0, 15) == 0) ? 12'($urandom_range(CELLS, 4095))
                                                : 12'($urandom_range(0, CELLS - 1));
      host_data  = 8'($urandom);
      step();
    end
    host_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
